// File: rtl/div_pkg.sv
// Shared types and constants for the shared restoring-division engine.
package div_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } state_e;

   localparam int unsigned DIV_WIDTH = 4;

   // Quotient reported when the divisor is zero
   localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/div_scheduler_if.sv
// Request/response bundle between the requesters, the divider and the writeback consumer.
interface div_scheduler_if
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH,
   parameter int unsigned NREQ  = 2
);
   localparam int unsigned IdW = $clog2(NREQ);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_dividend;
   logic [NREQ*WIDTH-1:0] req_divisor;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IdW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_quotient;
   logic [WIDTH-1:0]      rsp_remainder;
   logic                  rsp_div0;

   modport master (
      output req_valid, req_dividend, req_divisor, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_div0
   );

   modport slave (
      input  req_valid, req_dividend, req_divisor, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_div0
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or above ptr_i, wrapping modulo NREQ.
module rr_arbiter #(
   parameter int unsigned NREQ = 2
) (
   input  logic [NREQ-1:0]         req_i,
   input  logic [$clog2(NREQ)-1:0] ptr_i,
   input  logic                    en_i,
   output logic [NREQ-1:0]         gnt_o,
   output logic [$clog2(NREQ)-1:0] idx_o,
   output logic                    any_o
);
   localparam int unsigned IdW = $clog2(NREQ);

   int unsigned cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      cand  = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = (32'(ptr_i) + k) % NREQ;
         if (en_i && !any_o && req_i[cand]) begin
            any_o       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = IdW'(cand);
         end
      end
   end

endmodule

// File: rtl/div_scheduler.sv
// Shared multi-cycle restoring divider, one quotient bit per clock, round-robin arbitrated.
// Optional DIV_EARLY_EXIT_EN: dividend < divisor completes on the accept edge.
module div_scheduler
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH,
   parameter int unsigned NREQ  = 2
) (
   input logic            clk,
   input logic            rst,
   div_scheduler_if.slave bus
);
   localparam int unsigned IdW  = $clog2(NREQ);
   localparam int unsigned CntW = $clog2(WIDTH + 1);

   state_e           state_q, state_d;
   logic [IdW-1:0]   ptr_q, ptr_d;
   logic [IdW-1:0]   id_q, id_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   // Partial remainder always ends each step below the divisor, so WIDTH bits hold it
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [IdW-1:0]   rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_quo_q, rsp_quo_d;
   logic [WIDTH-1:0] rsp_rem_q, rsp_rem_d;
   logic             rsp_div0_q, rsp_div0_d;

   logic [NREQ-1:0]  gnt;
   logic [IdW-1:0]   gnt_idx;
   logic             gnt_any;
   logic [WIDTH-1:0] sel_dvd, sel_dvs;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] quo_sh;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .req_i (bus.req_valid),
      .ptr_i (ptr_q),
      .en_i  (state_q == StIdle),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (gnt_any)
   );

   always_comb begin
      sel_dvd    = bus.req_dividend[int'(gnt_idx)*WIDTH +: WIDTH];
      sel_dvs    = bus.req_divisor[int'(gnt_idx)*WIDTH +: WIDTH];
      state_d    = state_q;
      ptr_d      = ptr_q;
      id_d       = id_q;
      dvs_d      = dvs_q;
      quo_d      = quo_q;
      rem_d      = rem_q;
      cnt_d      = cnt_q;
      rsp_id_d   = rsp_id_q;
      rsp_quo_d  = rsp_quo_q;
      rsp_rem_d  = rsp_rem_q;
      rsp_div0_d = rsp_div0_q;

      // One restoring step on {R,Q}
      rem_sh = {rem_q, quo_q[WIDTH-1]};
      quo_sh = {quo_q[WIDTH-2:0], 1'b0};
      if (rem_sh >= {1'b0, dvs_q}) begin
         rem_sh    = rem_sh - {1'b0, dvs_q};
         quo_sh[0] = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (gnt_any) begin
               id_d  = gnt_idx;
               dvs_d = sel_dvs;
               quo_d = sel_dvd;
               rem_d = '0;
               cnt_d = '0;
               ptr_d = (gnt_idx == IdW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
               if (sel_dvs == '0) begin
                  state_d    = StDone;
                  rsp_id_d   = gnt_idx;
                  rsp_quo_d  = {WIDTH{DIV0_QUOT[0]}};
                  rsp_rem_d  = sel_dvd;
                  rsp_div0_d = 1'b1;
               end
`ifdef DIV_EARLY_EXIT_EN
               else if (sel_dvd < sel_dvs) begin
                  state_d    = StDone;
                  rsp_id_d   = gnt_idx;
                  rsp_quo_d  = '0;
                  rsp_rem_d  = sel_dvd;
                  rsp_div0_d = 1'b0;
               end
`endif
               else begin
                  state_d = StBusy;
               end
            end
         end
         StBusy: begin
            rem_d = rem_sh[WIDTH-1:0];
            quo_d = quo_sh;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) begin
               state_d    = StDone;
               rsp_id_d   = id_q;
               rsp_quo_d  = quo_sh;
               rsp_rem_d  = rem_sh[WIDTH-1:0];
               rsp_div0_d = 1'b0;
            end
         end
         StDone: begin
            if (bus.rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         ptr_q      <= '0;
         id_q       <= '0;
         dvs_q      <= '0;
         quo_q      <= '0;
         rem_q      <= '0;
         cnt_q      <= '0;
         rsp_id_q   <= '0;
         rsp_quo_q  <= '0;
         rsp_rem_q  <= '0;
         rsp_div0_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         id_q       <= id_d;
         dvs_q      <= dvs_d;
         quo_q      <= quo_d;
         rem_q      <= rem_d;
         cnt_q      <= cnt_d;
         rsp_id_q   <= rsp_id_d;
         rsp_quo_q  <= rsp_quo_d;
         rsp_rem_q  <= rsp_rem_d;
         rsp_div0_q <= rsp_div0_d;
      end
   end

   assign bus.req_ready     = gnt;
   assign bus.rsp_valid     = (state_q == StDone);
   assign bus.rsp_id        = rsp_id_q;
   assign bus.rsp_quotient  = rsp_quo_q;
   assign bus.rsp_remainder = rsp_rem_q;
   assign bus.rsp_div0      = rsp_div0_q;

endmodule
